tl_cntr: RTL and testbench
==========================

Name: tl_cntr

Overview:
Moore-type traffic light controller for an intersection of street A and street B. Traffic sensors Ta and Tb decide when each street's green phase ends. The controller cycles green -> yellow -> red between the two streets. It is a standalone leaf block, driven by a single system clock and an asynchronous active-low reset. Internally it is partitioned into next-state logic, a 2-bit state register and output decode logic.

Parameters:
- GREEN, 2'b00, light code for green
- YELLOW, 2'b01, light code for yellow
- RED, 2'b10, light code for red; code 2'b11 is unused
- S0/S1/S2/S3, 2'b00/2'b01/2'b10/2'b11, state encodings (local, not overridable)

Ports:
- clk  input  1  system clock; state updates on the rising edge
- reset_n  input  1  asynchronous reset, active low; forces state S0
- Ta  input  1  street A traffic sensor; 1 = traffic present on A
- Tb  input  1  street B traffic sensor; 1 = traffic present on B
- La  output  2  street A light (GREEN/YELLOW/RED code)
- Lb  output  2  street B light (GREEN/YELLOW/RED code)

Behaviour:
- Reset: reset_n=0 sets state to S0 immediately, regardless of clk.
  - Outputs follow combinationally: La=GREEN (00), Lb=RED (10).
  - Reset asserted mid-sequence (any state) returns to S0 at once.
  - While reset_n=0, clock edges are ignored.
- State register: 2 bits; updates only on rising clk while reset_n=1.
- Next-state logic (combinational, sampled at rising edge):
  - S0: Ta=1 -> S0; Ta=0 -> S1. Tb is ignored.
  - S1: -> S2 unconditionally.
  - S2: Tb=1 -> S2; Tb=0 -> S3. Ta is ignored.
  - S3: -> S0 unconditionally.
- Output decode (Moore; depends on state only, no input-to-output path):
  - S0: La=GREEN, Lb=RED
  - S1: La=YELLOW, Lb=RED
  - S2: La=RED, Lb=GREEN
  - S3: La=RED, Lb=YELLOW
- Latency: an output change appears one clk edge after the qualifying input condition is sampled.
- Yellow phases (S1, S3) last exactly one clock cycle.
- Green phases hold indefinitely while their own street's sensor stays at 1.
- Safety invariant: La and Lb are never both non-RED in the same cycle.
  - Exception: the green/yellow pairing defined above, where the other street is always RED.
- Illegal or unknown state values (e.g. X on the register) decode next state to S0 and both outputs to RED.
- Inputs are assumed synchronous to clk; no internal synchronizers are required.

Test Plan:
- reset_n=0 at t=0, Ta=1, Tb=0 -> La=00, Lb=10 before and across the first clk edge.
- reset_n=1, Ta=1 for one edge -> remain S0 (La=00, Lb=10); then Ta=0 at the next edge -> S1 (La=01, Lb=10).
- From S1 with Ta=1, Tb=1 -> one edge later S2 (La=10, Lb=00); Ta is ignored in S1.
- In S2 with Tb=1 for one edge -> remain S2; Tb=0 -> S3 (La=10, Lb=01); next edge -> S0 (La=00, Lb=10) regardless of Ta/Tb.
- Assert reset_n=0 between clk edges while in S2 or S3 -> outputs switch immediately to La=00, Lb=10, and state holds S0 on subsequent edges.
- Random Ta/Tb over ≥1000 cycles -> the safety invariant holds every cycle and each yellow phase lasts exactly one cycle.

Source files
------------

// File: rtl/tl_cntr.sv
// tl_cntr: Moore traffic light controller for streets A and B.
// Two-bit state register with separate next-state and output decode.
module tl_cntr #(
   parameter logic [1:0] GREEN  = 2'b00,
   parameter logic [1:0] YELLOW = 2'b01,
   parameter logic [1:0] RED    = 2'b10
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       Ta,
   input  logic       Tb,
   output logic [1:0] La,
   output logic [1:0] Lb
);

   localparam logic [1:0] S0 = 2'b00;
   localparam logic [1:0] S1 = 2'b01;
   localparam logic [1:0] S2 = 2'b10;
   localparam logic [1:0] S3 = 2'b11;

   logic [1:0] r_state;
   logic [1:0] w_next;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S0;
      end else begin
         r_state <= w_next;
      end
   end

   // Any unrecognised state value recovers to S0
   always_comb begin
      w_next = S0;
      case (r_state)
         S0:      w_next = Ta ? S0 : S1;
         S1:      w_next = S2;
         S2:      w_next = Tb ? S2 : S3;
         S3:      w_next = S0;
         default: w_next = S0;
      endcase
   end

   // Unknown state shows red on both streets
   always_comb begin
      La = RED;
      Lb = RED;
      case (r_state)
         S0: begin
            La = GREEN;
            Lb = RED;
         end
         S1: begin
            La = YELLOW;
            Lb = RED;
         end
         S2: begin
            La = RED;
            Lb = GREEN;
         end
         S3: begin
            La = RED;
            Lb = YELLOW;
         end
         default: begin
            La = RED;
            Lb = RED;
         end
      endcase
   end

endmodule

// File: tb/tb_tl_cntr.sv
// tb_tl_cntr: directed and random checks for the traffic light controller.
// Expected lights come from hand-computed values and a small reference model.
module tb_tl_cntr;

   localparam logic [1:0] G = 2'b00;
   localparam logic [1:0] Y = 2'b01;
   localparam logic [1:0] R = 2'b10;

   logic       clk;
   logic       reset_n;
   logic       Ta;
   logic       Tb;
   logic [1:0] La;
   logic [1:0] Lb;

   int checks;
   int failures;

   tl_cntr dut (
      .clk     (clk),
      .reset_n (reset_n),
      .Ta      (Ta),
      .Tb      (Tb),
      .La      (La),
      .Lb      (Lb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [1:0] obs,
                      input logic [1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk_lights(input string tag, input logic [1:0] ea,
                             input logic [1:0] eb);
      chk({tag, "_La"}, La, ea);
      chk({tag, "_Lb"}, Lb, eb);
   endtask

   // Apply sensors, take one rising edge, sample 1 time unit later
   task automatic step(input logic ta, input logic tb);
      Ta = ta;
      Tb = tb;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [1:0] model_next(input logic [1:0] s,
                                             input logic ta,
                                             input logic tb);
      if (s == 2'd0 && !ta) return 2'd1;
      if (s == 2'd0)        return 2'd0;
      if (s == 2'd1)        return 2'd2;
      if (s == 2'd2 && !tb) return 2'd3;
      if (s == 2'd2)        return 2'd2;
      return 2'd0;
   endfunction

   function automatic logic [1:0] model_la(input logic [1:0] s);
      return (s == 2'd0) ? G : (s == 2'd1) ? Y : R;
   endfunction

   function automatic logic [1:0] model_lb(input logic [1:0] s);
      return (s == 2'd2) ? G : (s == 2'd3) ? Y : R;
   endfunction

   initial begin
      logic [1:0] m;
      logic [1:0] pa;
      logic [1:0] pb;
      logic       rta;
      logic       rtb;
      checks   = 0;
      failures = 0;

      reset_n = 1'b0;
      Ta      = 1'b1;
      Tb      = 1'b0;
      #1;
      chk_lights("reset_t0", G, R);

      Ta = 1'b0;
      @(posedge clk);
      #1;
      chk_lights("reset_edge_ignored", G, R);
      @(posedge clk);
      #1;
      chk_lights("reset_edge_ignored2", G, R);

      #3;
      reset_n = 1'b1;
      @(negedge clk);

      step(1'b1, 1'b0);
      chk_lights("s0_hold_ta1", G, R);
      step(1'b1, 1'b1);
      chk_lights("s0_tb_ignored", G, R);
      step(1'b0, 1'b1);
      chk_lights("s0_to_s1", Y, R);
      step(1'b1, 1'b1);
      chk_lights("s1_to_s2", R, G);
      step(1'b1, 1'b1);
      chk_lights("s2_hold_tb1", R, G);
      step(1'b0, 1'b1);
      chk_lights("s2_ta_ignored", R, G);
      step(1'b1, 1'b0);
      chk_lights("s2_to_s3", R, Y);
      step(1'b1, 1'b1);
      chk_lights("s3_to_s0", G, R);

      step(1'b0, 1'b0);
      chk_lights("lap2_s1", Y, R);
      step(1'b0, 1'b0);
      chk_lights("lap2_s2", R, G);
      step(1'b0, 1'b0);
      chk_lights("lap2_s3", R, Y);

      #3;
      reset_n = 1'b0;
      #1;
      chk_lights("async_rst_s3", G, R);
      step(1'b0, 1'b0);
      chk_lights("rst_hold_s3", G, R);
      #2;
      reset_n = 1'b1;

      step(1'b0, 1'b0);
      chk_lights("relaunch_s1", Y, R);
      step(1'b0, 1'b1);
      chk_lights("relaunch_s2", R, G);
      #3;
      reset_n = 1'b0;
      #1;
      chk_lights("async_rst_s2", G, R);
      step(1'b0, 1'b1);
      chk_lights("rst_hold_s2", G, R);
      #2;
      reset_n = 1'b1;
      step(1'b1, 1'b0);
      chk_lights("post_rst_s0", G, R);

      m  = 2'd0;
      pa = G;
      pb = R;
      for (int i = 0; i < 1200; i++) begin
         rta = 1'($urandom_range(0, 1));
         rtb = 1'($urandom_range(0, 1));
         m   = model_next(m, rta, rtb);
         step(rta, rtb);
         chk_lights("rand", model_la(m), model_lb(m));
         checks++;
         assert (La == R || Lb == R) else begin
            failures++;
            $error("FAIL safety observed=%b/%b expected=one_red", La, Lb);
         end
         checks++;
         assert (!(pa == Y && La == Y) && !(pb == Y && Lb == Y)) else begin
            failures++;
            $error("FAIL yellow_len observed=%b/%b expected=single_cycle",
                   La, Lb);
         end
         pa = La;
         pb = Lb;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
